// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the 8-bit PC, captures the
//               instruction word into IR/IRPc/IRValid, and handles branch
//               redirect/flush, stall and end-of-program halt.
//               Optional FetchCount output when FETCH_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [7:0] LAST_ADDR = 8'd31,
  parameter logic [7:0] RESET_PC  = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Run,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [7:0]  BranchTarget,
  output logic [7:0]  InstrAddr,
  input  logic [15:0] ReadInstr,
  output logic [15:0] IR,
  output logic [7:0]  IRPc,
  output logic        IRValid,
  output logic        Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] FetchCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        capture;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ir_valid_d = 1'b0;
        if (Run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (BranchTaken) begin
          // Redirect and drop the wrong-path word; target lands one bubble later.
          pc_d       = BranchTarget;
          ir_valid_d = 1'b0;
        end else if (!Stall) begin
          capture    = 1'b1;
          ir_d       = ReadInstr;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          if (pc_q == LAST_ADDR) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + 8'd1;
          end
        end
      end
      S_HALT: begin
        if (BranchTaken) begin
          pc_d       = BranchTarget;
          ir_valid_d = 1'b0;
          state_d    = S_FETCH;
        end else if (!Stall) begin
          ir_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 8'h00;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign InstrAddr = pc_q;
  assign IR        = ir_q;
  assign IRPc      = ir_pc_q;
  assign IRValid   = ir_valid_q;
  assign Halted    = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (capture && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 16'h0000;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign FetchCount = fetch_count_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit; a second
//               instance with LAST_ADDR=255 covers halt at the top address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        run;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;

  logic [7:0]  addr_a, addr_b;
  logic [15:0] rd_a, rd_b;
  logic [15:0] ir_a, ir_b;
  logic [7:0]  irpc_a, irpc_b;
  logic        vld_a, vld_b;
  logic        hlt_a, hlt_b;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int vectors = 0;
  int errors  = 0;

  // Instruction memory contents: a fixed, address-dependent pattern.
  function automatic logic [15:0] mem(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  assign rd_a = mem(addr_a);
  assign rd_b = mem(addr_b);

  fetch_unit #(.LAST_ADDR(8'd31), .RESET_PC(8'd0)) u_dut_a (
    .clk(clk), .rst(rst), .Run(run), .Stall(stall),
    .BranchTaken(br_taken), .BranchTarget(br_target),
    .InstrAddr(addr_a), .ReadInstr(rd_a),
    .IR(ir_a), .IRPc(irpc_a), .IRValid(vld_a), .Halted(hlt_a)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(cnt_a)
`endif
  );

  fetch_unit #(.LAST_ADDR(8'd255), .RESET_PC(8'd0)) u_dut_b (
    .clk(clk), .rst(rst), .Run(run), .Stall(stall),
    .BranchTaken(br_taken), .BranchTarget(br_target),
    .InstrAddr(addr_b), .ReadInstr(rd_b),
    .IR(ir_b), .IRPc(irpc_b), .IRValid(vld_b), .Halted(hlt_b)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic exp_a(input string tag, input logic [7:0] pc, input logic v,
                       input logic [7:0] addr, input logic h);
    chk8({tag, ".IRPc"}, irpc_a, pc);
    chk1({tag, ".IRValid"}, vld_a, v);
    chk8({tag, ".InstrAddr"}, addr_a, addr);
    chk1({tag, ".Halted"}, hlt_a, h);
  endtask

  task automatic exp_b(input string tag, input logic [7:0] pc, input logic v,
                       input logic [7:0] addr, input logic h);
    chk8({tag, ".IRPc"}, irpc_b, pc);
    chk1({tag, ".IRValid"}, vld_b, v);
    chk8({tag, ".InstrAddr"}, addr_b, addr);
    chk1({tag, ".Halted"}, hlt_b, h);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    step();
    step();
    exp_a("reset", 8'h00, 1'b0, 8'h00, 1'b0);
    chk16("reset.IR", ir_a, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk16("reset.FetchCount", cnt_a, 16'h0000);
`endif

    // Leave IDLE: no capture on the Run edge.
    rst = 1'b0; run = 1'b1;
    step();
    exp_a("run_edge", 8'h00, 1'b0, 8'h00, 1'b0);
    run = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      step();
      exp_a("seq", 8'(k), 1'b1, 8'(k + 1), 1'b0);
      chk16("seq.IR", ir_a, mem(8'(k)));
    end

    // Three stalled cycles freeze everything at Mem[5].
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_a("stall", 8'h05, 1'b1, 8'h06, 1'b0);
      chk16("stall.IR", ir_a, mem(8'h05));
    end
    stall = 1'b0;
    step();
    exp_a("stall_rel", 8'h06, 1'b1, 8'h07, 1'b0);
    step();
    exp_a("pre_br", 8'h07, 1'b1, 8'h08, 1'b0);

    // Branch wins over a simultaneous stall.
    br_taken = 1'b1; br_target = 8'h10; stall = 1'b1;
    step();
    exp_a("br_bubble", 8'h07, 1'b0, 8'h10, 1'b0);
    br_taken = 1'b0; stall = 1'b0;
    step();
    exp_a("br_target", 8'h10, 1'b1, 8'h11, 1'b0);
    chk16("br_target.IR", ir_a, mem(8'h10));

    for (int k = 8'h11; k < 31; k++) begin
      step();
      exp_a("to_last", 8'(k), 1'b1, 8'(k + 1), 1'b0);
    end
    step();
    exp_a("last", 8'd31, 1'b1, 8'd31, 1'b1);
    chk16("last.IR", ir_a, mem(8'd31));

    // Stall in HALT keeps the last word valid.
    stall = 1'b1;
    step();
    exp_a("halt_stall", 8'd31, 1'b1, 8'd31, 1'b1);
    stall = 1'b0;
    step();
    exp_a("halt", 8'd31, 1'b0, 8'd31, 1'b1);
    step();
    exp_a("halt_hold", 8'd31, 1'b0, 8'd31, 1'b1);

    br_taken = 1'b1; br_target = 8'h11;
    step();
    exp_a("halt_br", 8'd31, 1'b0, 8'h11, 1'b0);
    br_taken = 1'b0;
    step();
    exp_a("halt_br_tgt", 8'h11, 1'b1, 8'h12, 1'b0);
    chk16("halt_br_tgt.IR", ir_a, mem(8'h11));

    // Top of address space: wrap on A, halt at 0xFF on B.
    br_taken = 1'b1; br_target = 8'hFE;
    step();
    exp_a("wrap_bubble", 8'h11, 1'b0, 8'hFE, 1'b0);
    chk8("top_bubble.InstrAddr", addr_b, 8'hFE);
    chk1("top_bubble.IRValid", vld_b, 1'b0);
    br_taken = 1'b0;
    step();
    exp_a("wrap_fe", 8'hFE, 1'b1, 8'hFF, 1'b0);
    exp_b("top_fe", 8'hFE, 1'b1, 8'hFF, 1'b0);
    step();
    exp_a("wrap_ff", 8'hFF, 1'b1, 8'h00, 1'b0);
    exp_b("top_ff", 8'hFF, 1'b1, 8'hFF, 1'b1);
    step();
    exp_a("wrap_00", 8'h00, 1'b1, 8'h01, 1'b0);
    chk16("wrap_00.IR", ir_a, mem(8'h00));
    exp_b("top_halt", 8'hFF, 1'b0, 8'hFF, 1'b1);

    // Branch to the current PC re-fetches after one bubble.
    br_taken = 1'b1; br_target = 8'h01;
    step();
    exp_a("self_br", 8'h00, 1'b0, 8'h01, 1'b0);
    br_taken = 1'b0;
    step();
    exp_a("self_br_tgt", 8'h01, 1'b1, 8'h02, 1'b0);
    chk16("self_br_tgt.IR", ir_a, mem(8'h01));

    // Reset overrides a simultaneous branch during a stall.
    stall = 1'b1;
    step();
    rst = 1'b1; br_taken = 1'b1; br_target = 8'h40;
    step();
    exp_a("rst_mid", 8'h00, 1'b0, 8'h00, 1'b0);
    chk16("rst_mid.IR", ir_a, 16'h0000);
    exp_b("rst_mid_b", 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk16("rst_mid.FetchCount", cnt_a, 16'h0000);
`endif

    // IDLE ignores branch and stall.
    rst = 1'b0; stall = 1'b0; br_target = 8'h50;
    step();
    exp_a("idle_br", 8'h00, 1'b0, 8'h00, 1'b0);
    br_taken = 1'b0; run = 1'b1;
    step();
    run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_a("refetch", 8'(k), 1'b1, 8'(k + 1), 1'b0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk16("count4.FetchCount", cnt_a, 16'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 16-bit lab CPU, directly upstream of the combinational instruction memory and directly upstream of decode. It owns the 8-bit program counter and drives InstrAddr. It registers the returned ReadInstr into an instruction register (IR) together with its PC, and presents both to decode with a valid flag. It handles run/idle, stall, taken-branch redirect with flush, and end-of-program halt.

Parameters:
LAST_ADDR, 31, address of the final program instruction; fetching it sends the FSM to HALT.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
Run  input  1  level; leaves IDLE when high
Stall  input  1  decode back-pressure; holds PC, IR, IRPc, IRValid
BranchTaken  input  1  one-cycle pulse from execute; redirect fetch
BranchTarget  input  8  absolute redirect address, sampled with BranchTaken
InstrAddr  output  8  address to instruction memory; equals PC register
ReadInstr  input  16  instruction word from memory, combinational from InstrAddr
IR  output  16  registered instruction to decode
IRPc  output  8  address IR was fetched from
IRValid  output  1  IR holds a valid instruction this cycle
Halted  output  1  high while FSM is in HALT
FetchCount  output  16  only when FETCH_PERF_CNT_EN is defined

Behaviour:
- Reset (rst high at edge): PC=RESET_PC, IR=16'h0000, IRPc=0, IRValid=0, state=IDLE. Halted=0, FetchCount=0. rst overrides everything, including mid-fetch and mid-branch.
- InstrAddr = PC continuously. Memory is combinational, so an instruction is captured at the edge after its address is driven.
- Input priority in FETCH/HALT: rst > BranchTaken > Stall > normal.
- FSM states: IDLE, FETCH, HALT.
- IDLE: PC held, IRValid=0. Run=1 at edge -> FETCH, with no capture on that edge. BranchTaken and Stall are ignored.
- FETCH normal (no branch, no stall):
  - IR<=ReadInstr, IRPc<=PC, IRValid<=1, PC<=PC+1.
  - PC is 8-bit modulo and wraps from 255 to 0.
  - If PC==LAST_ADDR at the capture, the state goes to HALT and PC holds at LAST_ADDR; no increment.
- FETCH stall: PC, IR, IRPc and IRValid all hold; state unchanged.
- BranchTaken (FETCH or HALT), stall ignored that cycle:
  - PC<=BranchTarget, IRValid<=0 (flushes the in-flight wrong-path word), state<=FETCH.
  - The target instruction appears on IR with IRValid=1 at the second edge after the BranchTaken edge. That is exactly one bubble cycle, barring stall.
- HALT:
  - The last instruction stays on IR with IRValid=1 until the first non-stalled edge in HALT, then IRValid<=0.
  - PC holds; no further captures.
  - Exit only by BranchTaken (-> FETCH at target) or rst.
- Halted=1 exactly while state==HALT (registered state decode).
- Run is not sampled outside IDLE.
- Branch to LAST_ADDR: fetched once, then HALT as normal.
- Branch with BranchTarget==PC: legal; re-fetches with one bubble.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds output FetchCount[15:0]. It increments on every edge where IR captures a new instruction (normal FETCH capture). It saturates at 16'hFFFF and is cleared only by rst. Stalls, bubbles and HALT cycles do not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then Run=1 for one cycle, no stall -> after the edge leaving IDLE, IR sequence is Mem[0],Mem[1],... with IRPc 0,1,2 and IRValid=1 every cycle. InstrAddr leads IRPc by 1.
- Stall high for 3 cycles while IRPc=5 -> IR/IRPc/IRValid/InstrAddr frozen at Mem[5]/5/1/6; on release IRPc goes 6.
- BranchTaken with BranchTarget=0x10 while PC=0x08, Stall also high -> next cycle IRValid=0, InstrAddr=0x10. The following cycle IR=Mem[0x10], IRPc=0x10, IRValid=1.
- Run through LAST_ADDR=31 -> IRPc=31 with IRValid=1 for one cycle, then IRValid=0, Halted=1, InstrAddr stays 31. BranchTaken to 0x11 -> Halted=0, IRPc=0x11 after one bubble.
- LAST_ADDR=255, branch to 0xFE -> IRPc 0xFE, 0xFF then HALT; with LAST_ADDR=31 and a branch to 0xFF, IRPc 0xFF then 0x00, confirming wrap.
- rst asserted the same cycle as BranchTaken, mid-stall -> all outputs return to reset values, state IDLE, FetchCount=0 (if enabled). After Run, the counter equals the number of IRValid rising captures, e.g. 4 after 4 fetches.
